// File: rtl/price_disp_pkg.sv
// -----------------------------------------------------------------------------
// price_disp_pkg
// Shared definitions for the price display path: default widths of the binary
// price and its BCD form, the blank digit code, the number of digits that are
// always shown, the decoder state encoding and a helper for counter sizing.
// -----------------------------------------------------------------------------
package price_disp_pkg;

  localparam int DEF_IN_W   = 19;  // binary price width, max 524287 centimos
  localparam int DEF_DIGITS = 6;   // BCD digits on the price display

  // Digit code the 7-segment driver renders as an unlit digit.
  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Euro units plus two cent digits are always displayed ("0.05").
  localparam int SHOWN_DIGITS = 3;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // Bits needed to hold a bit counter loaded with w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_IN_W);

endpackage : price_disp_pkg

// File: rtl/price_bcd_add3.sv
// -----------------------------------------------------------------------------
// price_bcd_add3
// Combinational double-dabble corrector for one BCD digit: digits of 5 or more
// get 3 added so that the following left shift carries into the next digit.
//
// Ports:
//   din   [3:0]  scratch digit before correction
//   dout  [3:0]  corrected digit
// -----------------------------------------------------------------------------
module price_bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Inputs are always 0..9 while converting, so the sum never exceeds 12.
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule : price_bcd_add3

// File: rtl/price_bcd_decoder.sv
// -----------------------------------------------------------------------------
// price_bcd_decoder
// Sequential binary-to-BCD converter for the scale's price display. A start
// request captures the binary price; one bit is shifted through the
// double-dabble scratch register per clock, and after IN_W shifts the result
// is loaded into bcd together with a one-cycle done pulse.
//
// Build option:
//   LEAD_ZERO_BLANK_EN  when defined, leading zero digits from DIGITS-1 down to
//                       digit 3 are replaced with BLANK_CODE on load.
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   synchronous active-low reset
//   start   conversion request, honoured only while idle
//   precof  [IN_W-1:0]      binary price in centimos, captured on accept
//   busy    high while a conversion is running
//   done    one-cycle pulse when bcd is updated
//   bcd     [4*DIGITS-1:0]  packed BCD result, digit 0 in bits [3:0]
// -----------------------------------------------------------------------------
module price_bcd_decoder
  import price_disp_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       precof,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CNT_W = cnt_width(IN_W);
  localparam int BCD_W = 4 * DIGITS;

  state_t             state, state_next;
  logic [IN_W-1:0]    bin_sr;
  logic [BCD_W-1:0]   scratch;
  logic [CNT_W-1:0]   cnt;

  logic               accept;
  logic               shift_en;
  logic               finish;

  logic [BCD_W-1:0]   corrected;
  logic [BCD_W-1:0]   scratch_next;
  logic [IN_W-1:0]    bin_next;
  logic [BCD_W-1:0]   result;

  // The top corrected bit is shifted out and discarded; it is always zero
  // because the digit count covers the full input range.
  logic               unused_top;

  // ---------------------------------------------------------------------------
  // Per-digit add-3 correction of the scratch register.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    price_bcd_add3 u_add3 (
      .din  (scratch[4*g +: 4]),
      .dout (corrected[4*g +: 4])
    );
  end

  assign unused_top   = corrected[BCD_W-1];
  assign scratch_next = {corrected[BCD_W-2:0], bin_sr[IN_W-1]};
  assign bin_next     = {bin_sr[IN_W-2:0], 1'b0};

  // ---------------------------------------------------------------------------
  // Next-state and control decode.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned, which would infer a latch.
    state_next = state;
    accept     = 1'b0;
    shift_en   = 1'b0;
    finish     = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        // cnt == 1 marks the IN_W-th shift edge.
        if (cnt == CNT_W'(1)) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result formatting: raw BCD, optionally with leading zeros blanked.
  // ---------------------------------------------------------------------------
`ifdef LEAD_ZERO_BLANK_EN
  logic leading;

  always_comb begin
    result  = scratch_next;
    leading = 1'b1;
    for (int i = DIGITS - 1; i >= SHOWN_DIGITS; i--) begin
      if (leading && (scratch_next[4*i +: 4] == 4'd0)) begin
        result[4*i +: 4] = BLANK_CODE;
      end else begin
        leading = 1'b0;
      end
    end
  end
`else
  assign result = scratch_next;
`endif

  // ---------------------------------------------------------------------------
  // State register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_sr  <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd     <= '0;
      done    <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        bin_sr  <= precof;
        scratch <= '0;
        cnt     <= CNT_W'(IN_W);
      end else if (shift_en) begin
        bin_sr  <= bin_next;
        scratch <= scratch_next;
        cnt     <= cnt - CNT_W'(1);
        // bcd is only touched on completion, never with partial values.
        if (finish) bcd <= result;
      end
    end
  end

  assign busy = (state == SHIFT);

endmodule : price_bcd_decoder

// File: tb/tb_price_bcd_decoder.sv
// -----------------------------------------------------------------------------
// tb_price_bcd_decoder
// Self-checking bench for price_bcd_decoder: a table of directed prices with
// hand-computed BCD, hand-written handshake sequences (ignored start, reset
// abort, back-to-back) and a batch of random prices checked against a
// decimal-division reference.
// -----------------------------------------------------------------------------
module tb_price_bcd_decoder;

  localparam int IN_W   = 19;
  localparam int DIGITS = 6;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int LAT    = IN_W;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [IN_W-1:0]  precof;
  logic             busy;
  logic             done;
  logic [BCD_W-1:0] bcd;

  int checks;
  int errors;

  price_bcd_decoder #(
    .IN_W   (IN_W),
    .DIGITS (DIGITS)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .precof (precof),
    .busy   (busy),
    .done   (done),
    .bcd    (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IN_W-1:0]  price;
    logic [BCD_W-1:0] exp_raw;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Applies display blanking to a raw BCD value in the blanking build.
  function automatic logic [BCD_W-1:0] fmt(input logic [BCD_W-1:0] raw);
    logic [BCD_W-1:0] r;
    r = raw;
`ifdef LEAD_ZERO_BLANK_EN
    for (int i = DIGITS - 1; i >= 3; i--) begin
      if (r[4*i +: 4] != 4'd0) break;
      r[4*i +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction

  // Decimal reference by repeated division.
  function automatic logic [BCD_W-1:0] model(input int unsigned v);
    logic [BCD_W-1:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return fmt(r);
  endfunction

  // Counts rising edges until done is seen (sampled 1 after the edge).
  // Also reports whether busy dropped before done. n = budget+1 on timeout.
  task automatic wait_done(input int budget, output int n, output bit early);
    n = budget + 1;
    early = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = k;
        break;
      end
      if (!busy) early = 1'b1;
    end
  endtask

  // Counts done pulses over a window of cycles.
  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
  endtask

  // One full conversion with latency, busy, bcd and pulse-width checks.
  task automatic run_conv(input logic [IN_W-1:0] v, input string tag);
    int n;
    bit early;
    @(negedge clk);
    precof = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    precof = IN_W'($urandom);  // must not disturb the running conversion
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(LAT + 10, n, early);
    check({tag, "_latency"}, 64'(n), 64'(LAT));
    check({tag, "_busy_early_drop"}, 64'(early), 64'd0);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_bcd"}, 64'(bcd), 64'(model(32'(v))));
    @(posedge clk);
    #1;
    check({tag, "_done_width"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    int cnt;
    bit early;

    checks = 0;
    errors = 0;

    vecs[0] = '{19'd705,    24'h000705};
    vecs[1] = '{19'd524287, 24'h524287};
    vecs[2] = '{19'd0,      24'h000000};
    vecs[3] = '{19'd1,      24'h000001};
    vecs[4] = '{19'd999,    24'h000999};
    vecs[5] = '{19'd1000,   24'h001000};
    vecs[6] = '{19'd99999,  24'h099999};
    vecs[7] = '{19'd100000, 24'h100000};

    rst_n  = 1'b0;
    start  = 1'b0;
    precof = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_bcd",  64'(bcd),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    foreach (vecs[i]) begin
      int n2;
      bit e2;
      @(negedge clk);
      precof = vecs[i].price;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      wait_done(LAT + 10, n2, e2);
      check($sformatf("vec%0d_latency", i), 64'(n2), 64'(LAT));
      check($sformatf("vec%0d_bcd", i), 64'(bcd), 64'(fmt(vecs[i].exp_raw)));
    end

    run_conv(19'd705, "p705");

    // Second start during SHIFT is ignored.
    @(negedge clk);
    precof = 19'd12345;
    start  = 1'b1;
    @(negedge clk);           // past E0
    start  = 1'b0;
    repeat (4) @(negedge clk); // past E4
    precof = 19'd999;
    start  = 1'b1;             // seen at E5 while busy
    @(negedge clk);
    start  = 1'b0;
    wait_done(LAT + 10, n, early);
    check("ignored_latency", 64'(n), 64'(LAT - 5));
    check("ignored_bcd", 64'(bcd), 64'(fmt(24'h012345)));
    count_done(25, cnt);
    check("ignored_single_done", 64'(cnt), 64'd0);

    // Reset mid-conversion aborts it.
    @(negedge clk);
    precof = 19'd4321;
    start  = 1'b1;
    @(negedge clk);           // past E0
    start  = 1'b0;
    repeat (9) @(negedge clk); // past E9
    rst_n = 1'b0;
    @(posedge clk);            // E10 applies reset
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_bcd",  64'(bcd),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(25, cnt);
    check("abort_no_done", 64'(cnt), 64'd0);
    run_conv(19'd4321, "after_abort");

    // Back-to-back: second start presented in the done cycle.
    @(negedge clk);
    precof = 19'd100;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(LAT + 10, n, early);
    check("b2b_first_latency", 64'(n), 64'(LAT));
    check("b2b_first_bcd", 64'(bcd), 64'(fmt(24'h000100)));
    precof = 19'd99999;
    start  = 1'b1;
    @(posedge clk);            // E20 accepts
    #1;
    start  = 1'b0;
    check("b2b_second_busy", 64'(busy), 64'd1);
    wait_done(LAT + 10, n, early);
    check("b2b_second_latency", 64'(n), 64'(LAT));
    check("b2b_second_bcd", 64'(bcd), 64'(fmt(24'h099999)));

    // Random prices against the decimal reference.
    for (int r = 0; r < 1000; r++) begin
      int unsigned v;
      int n3;
      bit e3;
      v = $urandom_range(524287, 0);
      @(negedge clk);
      precof = IN_W'(v);
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      wait_done(LAT + 10, n3, e3);
      check($sformatf("rand%0d_latency", r), 64'(n3), 64'(LAT));
      check($sformatf("rand%0d_bcd_%0d", r, v), 64'(bcd), 64'(model(v)));
      @(posedge clk);
      #1;
      check($sformatf("rand%0d_done_width", r), 64'(done), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_price_bcd_decoder

// File: doc/price_bcd_decoder.md
Name: price_bcd_decoder

Overview:
Sequential binary-to-BCD decoder for the scale's final price output. It consumes the 19-bit price in centimos produced by the weight×price multiplier and emits six packed BCD digits for the 7-segment price display driver. It uses a shift-and-add-3 (double-dabble) algorithm, one bit per clock, with a start/busy/done handshake.

Parameters:
IN_W, 19, width of the binary price input (max 524287 centimos).
DIGITS, 6, number of BCD digits produced. Must satisfy 10^DIGITS > 2^IN_W − 1.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request conversion; sampled only when not busy
precof  input  IN_W  binary price in centimos; captured on the accepting edge
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bcd is updated
bcd  output  4*DIGITS  packed BCD result; digit 0 (units of centimos) in bits [3:0]

Behaviour:
- Clocking and reset: one clock domain, clk. rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge):
  - state returns to IDLE.
  - busy=0, done=0, bcd=0, internal shift and BCD registers cleared.
  - Reset mid-conversion aborts it; no done pulse follows.
- States:
  - IDLE: busy=0. At an edge with start=1, capture precof into the binary shift register, clear the BCD scratch, load the bit counter with IN_W, go to SHIFT.
  - SHIFT: busy=1. Each edge: add 3 to every scratch digit ≥5, then shift {scratch, binary} left by 1 and decrement the counter.
  - After the IN_W-th shift edge: load bcd from scratch, set done=1 for exactly one cycle, set busy=0, return to IDLE.
- Latency: start captured at edge E0; bcd/done valid after edge E(IN_W), i.e. 19 cycles for the default.
- bcd holds its last result until the next completion. It never shows intermediate values.
- start while busy=1 is ignored; there is no queueing. precof changes during SHIFT have no effect.
- start in the done cycle (state IDLE) is accepted, giving back-to-back conversions every IN_W+1 cycles.
- Inputs that cannot be represented are impossible given the DIGITS constraint, so there is no overflow output.

Optional Feature:
- Macro: LEAD_ZERO_BLANK_EN.
- Defined: when loading bcd, leading zero digits at indices DIGITS−1 down to 3 are replaced by BLANK_CODE (4'hF). Blanking stops at the first nonzero digit. Digits 2..0 (euro units and cents) are never blanked, so the display reads like "0.05".
- Undefined: bcd is raw BCD and 4'hF never appears.
- Timing and handshake are identical in both builds.

Decomposition:
- Package price_disp_pkg:
  - IN_W and DIGITS defaults.
  - BLANK_CODE = 4'hF.
  - Number of always-shown digits = 3.
  - State enum {IDLE, SHIFT}.
  - Counter width, computed as $clog2(IN_W+1).
- Sub-module price_bcd_add3: combinational single-digit corrector (in ≥5 ? in+3 : in), instantiated DIGITS times via generate.

Test Plan:
- precof=705 (1500 g × 470 c/kg ÷ 1000), start one cycle → busy for 19 cycles, done pulse at edge E19, bcd=24'h000705. With LEAD_ZERO_BLANK_EN: 24'hFFF705.
- precof=524287 → bcd=24'h524287. precof=0 → bcd=24'h000000, or 24'hFFF000 with LEAD_ZERO_BLANK_EN.
- Start 12345, pulse start again with precof=999 at cycle 5 → second start ignored, a single done, bcd=24'h012345.
- Start 4321, drive rst_n=0 at cycle 10 → next cycle busy=0, done=0, bcd=0. No done pulse within 25 cycles. A fresh start then works normally.
- Start 100, then start with 99999 during the done cycle → done at E19 with 24'h000100, second done at E39 with 24'h099999.
- Random 1000 values in 0..524287 → bcd matches a software decimal conversion. done is asserted exactly once per accepted start.
